// File: rtl/axil_arb_pkg.sv
// Shared widths, FSM state encodings and default timeout code for the AXI-Lite request arbiter.
package axil_arb_pkg;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int RW = 4;

  localparam logic [RW-1:0] TIMEOUT_CODE_DEF = 4'hF;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE  = 2'd0;
  localparam arb_state_t ST_ISSUE = 2'd1;
  localparam arb_state_t ST_WAIT  = 2'd2;
  localparam arb_state_t ST_RESP  = 2'd3;

endpackage

// File: rtl/axil_rr_pick.sv
// Combinational picker: first asserted request found searching upward from ptr, wrapping.
// A constant zero pointer turns it into a fixed lowest-index-wins priority encoder.
module axil_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               any
);

  int cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(ptr) + i) % NUM_REQ;
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/axil_req_arbiter.sv
// Serialises NUM_REQ valid/ready command ports onto one single-tick AXI-Lite master, one transaction at a time,
// with a WAIT timeout. Define AXIL_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module axil_req_arbiter
  import axil_arb_pkg::*;
#(
  parameter int            NUM_REQ        = 4,
  parameter int            TIMEOUT_CYCLES = 255,
  parameter logic [RW-1:0] TIMEOUT_CODE   = TIMEOUT_CODE_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [AW*NUM_REQ-1:0] req_addr,
  input  logic [DW*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]         rsp_rdata,
  output logic [RW-1:0]         rsp_code,
  output logic                  m_read,
  output logic                  m_write,
  output logic [AW-1:0]         m_addr,
  output logic [DW-1:0]         m_wdata,
  input  logic                  m_rd_done,
  input  logic [DW-1:0]         m_rdata,
  input  logic                  m_wr_done,
  input  logic [RW-1:0]         m_bresp
);

  localparam int          IW     = $clog2(NUM_REQ);
  localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);

  arb_state_t         state;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_any;
  logic [IW-1:0]      ptr;

  logic [IW-1:0]      lat_idx;
  logic               lat_write;
  logic [AW-1:0]      lat_addr;
  logic [DW-1:0]      lat_wdata;
  logic [15:0]        cnt;
  logic [15:0]        cnt_nxt;
  logic [DW-1:0]      rsp_rdata_q;
  logic [RW-1:0]      rsp_code_q;
  logic               done_hit;

  axil_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

`ifdef AXIL_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [IW-1:0] ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (state == ST_IDLE && pick_any) begin
      ptr_q <= (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

  assign ptr = ptr_q;
`endif

  // Only the completion matching the issued direction can end a transaction.
  assign done_hit = lat_write ? m_wr_done : m_rd_done;
  assign cnt_nxt  = cnt + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      lat_idx     <= '0;
      lat_write   <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      cnt         <= '0;
      rsp_rdata_q <= '0;
      rsp_code_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            lat_idx   <= pick_idx;
            lat_write <= req_write[pick_idx];
            lat_addr  <= req_addr[pick_idx*AW +: AW];
            lat_wdata <= req_wdata[pick_idx*DW +: DW];
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt <= cnt_nxt;
          // A completion in the final counted cycle still beats the timeout.
          if (done_hit) begin
            rsp_rdata_q <= lat_write ? '0 : m_rdata;
            rsp_code_q  <= lat_write ? m_bresp : '0;
            state       <= ST_RESP;
          end else if (cnt_nxt == TO_LIM) begin
            rsp_rdata_q <= '0;
            rsp_code_q  <= TIMEOUT_CODE;
            state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready = (state == ST_IDLE && !rst) ? pick_gnt : '0;

  assign m_read  = (state == ST_ISSUE) && !lat_write;
  assign m_write = (state == ST_ISSUE) && lat_write;
  assign m_addr  = (state == ST_ISSUE || state == ST_WAIT) ? lat_addr : '0;
  assign m_wdata = (state == ST_ISSUE || state == ST_WAIT) ? lat_wdata : '0;

  always_comb begin
    rsp_valid = '0;
    if (state == ST_RESP) begin
      rsp_valid[lat_idx] = 1'b1;
    end
  end

  assign rsp_rdata = (state == ST_RESP) ? rsp_rdata_q : '0;
  assign rsp_code  = (state == ST_RESP) ? rsp_code_q : '0;

endmodule

// File: tb/tb_axil_req_arbiter.sv
// Directed bench for axil_req_arbiter: reset, read/write, fairness, timeout boundary, stray completions, mid-transaction reset.
module tb_axil_req_arbiter;

  localparam int NR = 4;
  localparam int TO = 8;

  logic          clk;
  logic          rst;
  logic [NR-1:0] req_valid;
  logic [NR-1:0] req_write;
  logic [4*NR-1:0] req_addr;
  logic [8*NR-1:0] req_wdata;
  logic [NR-1:0] req_ready;
  logic [NR-1:0] rsp_valid;
  logic [7:0]    rsp_rdata;
  logic [3:0]    rsp_code;
  logic          m_read;
  logic          m_write;
  logic [3:0]    m_addr;
  logic [7:0]    m_wdata;
  logic          m_rd_done;
  logic [7:0]    m_rdata;
  logic          m_wr_done;
  logic [3:0]    m_bresp;

  int n_vec = 0;
  int n_bad = 0;

  axil_req_arbiter #(
    .NUM_REQ        (NR),
    .TIMEOUT_CYCLES (TO),
    .TIMEOUT_CODE   (4'hF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_code  (rsp_code),
    .m_read    (m_read),
    .m_write   (m_write),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_rd_done (m_rd_done),
    .m_rdata   (m_rdata),
    .m_wr_done (m_wr_done),
    .m_bresp   (m_bresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance to 2 time units after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Entered in an IDLE cycle with requests already driven; returns 3 units into the following IDLE cycle.
  // dly = WAIT cycle carrying the done pulse (0 = none, timeout); stray = wrong-direction pulse in WAIT cycle 1.
  task automatic run_txn(input string tag, input logic [NR-1:0] gnt, input logic wr,
                         input logic [3:0] addr, input logic [7:0] wd, input int dly,
                         input bit stray, input logic [7:0] rd, input logic [3:0] br, input bit drop);
    logic [7:0] exp_rd;
    logic [3:0] exp_code;
    int         nw;
    exp_rd   = (dly == 0 || wr) ? 8'h00 : rd;
    exp_code = (dly == 0) ? 4'hF : (wr ? br : 4'h0);
    nw       = (dly == 0) ? TO : dly;
    #3;
    chk({tag, " ready"}, 32'(req_ready), 32'(gnt));
    cyc();
    if (drop) req_valid = req_valid & ~gnt;
    #1;
    chk({tag, " cmd"}, 32'({m_write, m_read}), wr ? 32'd2 : 32'd1);
    chk({tag, " addr"}, 32'(m_addr), 32'(addr));
    chk({tag, " wdata"}, 32'(m_wdata), 32'(wd));
    for (int k = 1; k <= nw; k++) begin
      cyc();
      m_rd_done = 1'b0;
      m_wr_done = 1'b0;
      if (k == dly) begin
        if (wr) begin m_wr_done = 1'b1; m_bresp = br; end
        else    begin m_rd_done = 1'b1; m_rdata = rd; end
      end else if (stray && k == 1) begin
        if (wr) begin m_rd_done = 1'b1; m_rdata = 8'hEE; end
        else    begin m_wr_done = 1'b1; m_bresp = 4'h9; end
      end
      #1;
      chk({tag, " wait"}, 32'({rsp_valid, m_read, m_write}), 32'd0);
    end
    cyc();
    m_rd_done = 1'b0;
    m_wr_done = 1'b0;
    m_rdata   = 8'h00;
    m_bresp   = 4'h0;
    #1;
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(gnt));
    chk({tag, " rsp_rdata"}, 32'(rsp_rdata), 32'(exp_rd));
    chk({tag, " rsp_code"}, 32'(rsp_code), 32'(exp_code));
    cyc();
    #1;
    chk({tag, " idle"}, 32'({rsp_valid, m_addr, m_wdata}), 32'd0);
  endtask

  int ord [5];

  initial begin
    rst = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    m_rd_done = 1'b0; m_rdata = '0; m_wr_done = 1'b0; m_bresp = '0;
    repeat (3) cyc();
    #1;
    chk("reset ready/rsp", 32'({req_ready, rsp_valid}), 32'd0);
    chk("reset master", 32'({m_read, m_write, m_addr, m_wdata}), 32'd0);
    chk("reset rsp data", 32'({rsp_rdata, rsp_code}), 32'd0);
    rst = 1'b0;
    cyc();

    // Fairness: everyone valid; requesters 1 and 3 write.
`ifdef AXIL_ARB_FIXED_PRIO_EN
    ord = '{0, 0, 0, 0, 0};
`else
    ord = '{0, 1, 2, 3, 0};
`endif
    req_valid = 4'b1111;
    req_write = 4'b1010;
    req_addr  = 16'hD9A1;
    req_wdata = 32'h44332211;
    for (int i = 0; i < 5; i++) begin
      case (ord[i])
        0: run_txn("fair0", 4'b0001, 1'b0, 4'h1, 8'h11, 1, 1'b0, 8'h10, 4'h0, 1'b0);
        1: run_txn("fair1", 4'b0010, 1'b1, 4'hA, 8'h22, 1, 1'b0, 8'h11, 4'h1, 1'b0);
        2: run_txn("fair2", 4'b0100, 1'b0, 4'h9, 8'h33, 1, 1'b0, 8'h12, 4'h2, 1'b0);
        default: run_txn("fair3", 4'b1000, 1'b1, 4'hD, 8'h44, 1, 1'b0, 8'h13, 4'h3, 1'b0);
      endcase
    end
    req_valid = '0;

    // Single read: requester 1, addr 3, data A5 two cycles after m_read.
    req_valid = 4'b0010; req_write = 4'b0000; req_addr = 16'h0030; req_wdata = 32'h0;
    run_txn("read", 4'b0010, 1'b0, 4'h3, 8'h00, 2, 1'b0, 8'hA5, 4'h0, 1'b1);

    // Single write: requester 0 writes 5C to addr 7.
    req_valid = 4'b0001; req_write = 4'b0001; req_addr = 16'h0007; req_wdata = 32'h0000005C;
    run_txn("write", 4'b0001, 1'b1, 4'h7, 8'h5C, 1, 1'b0, 8'h00, 4'h0, 1'b1);

    // Timeout: requester 3 write, silent slave.
    req_valid = 4'b1000; req_write = 4'b1000; req_addr = 16'hE000; req_wdata = 32'h77000000;
    run_txn("timeout", 4'b1000, 1'b1, 4'hE, 8'h77, 0, 1'b0, 8'h00, 4'h0, 1'b1);

    // Stray read completion while idle must not produce a response.
    req_valid = '0;
    m_rd_done = 1'b1; m_rdata = 8'hEE;
    cyc();
    m_rd_done = 1'b0; m_rdata = 8'h00;
    #1;
    chk("stray idle", 32'({rsp_valid, m_read, m_write}), 32'd0);
    #2;

    // Read with a wrong-direction pulse first; real completion later.
    req_valid = 4'b0100; req_write = 4'b0000; req_addr = 16'h0500; req_wdata = 32'h00AB0000;
    run_txn("stray wait", 4'b0100, 1'b0, 4'h5, 8'hAB, 3, 1'b1, 8'h3C, 4'h0, 1'b1);

    // Completion in the very cycle the timeout count is reached.
    req_valid = 4'b0010; req_write = 4'b0000; req_addr = 16'h0020; req_wdata = 32'h0;
    run_txn("edge done", 4'b0010, 1'b0, 4'h2, 8'h00, TO, 1'b0, 8'h81, 4'h0, 1'b1);

    // Reset while waiting on requester 2's read.
    req_valid = 4'b0100; req_write = 4'b0000; req_addr = 16'h0600; req_wdata = 32'h0;
    #3;
    chk("rst_txn ready", 32'(req_ready), 32'b0100);
    cyc();
    req_valid = '0;
    cyc();
    rst = 1'b1;
    cyc();
    m_rd_done = 1'b1; m_rdata = 8'h99;
    #1;
    chk("rst outputs", 32'({req_ready, rsp_valid, m_read, m_write, m_addr, m_wdata}), 32'd0);
    chk("rst rsp data", 32'({rsp_rdata, rsp_code}), 32'd0);
    rst = 1'b0;
    m_rd_done = 1'b0; m_rdata = 8'h00;
    for (int i = 0; i < 3; i++) begin
      cyc();
      #1;
      chk("rst no rsp", 32'({rsp_valid, m_read, m_write}), 32'd0);
    end

    // Pointer cleared by reset: 0 beats 3.
    req_valid = 4'b1001; req_write = 4'b0000; req_addr = 16'hB004; req_wdata = 32'h66000012;
    run_txn("post rst", 4'b0001, 1'b0, 4'h4, 8'h12, 2, 1'b0, 8'h5A, 4'h0, 1'b1);
    req_valid = '0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/axil_req_arbiter.md
Name: axil_req_arbiter

Overview:
Shares one AXI-Lite master, with its single-tick read/write command interface, among NUM_REQ independent requesters. Each requester gets a simple valid/ready command port and a one-cycle response strobe. The block serialises commands so exactly one transaction is outstanding at a time. It enforces a per-transaction timeout, so a silent slave cannot hang the bus.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 255, cycles in WAIT before a transaction is aborted with an error (1..65535)
TIMEOUT_CODE, 4'hF, response code returned on timeout

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester command valid
req_write  in  NUM_REQ  1 = write, 0 = read
req_addr  in  4*NUM_REQ  packed addresses; requester i uses bits [4i+3:4i]
req_wdata  in  8*NUM_REQ  packed write data; requester i uses bits [8i+7:8i]
req_ready  out  NUM_REQ  one-hot, one-cycle command-accept pulse
rsp_valid  out  NUM_REQ  one-hot, one-cycle response strobe
rsp_rdata  out  8  read data, valid with rsp_valid
rsp_code  out  4  write response or TIMEOUT_CODE, valid with rsp_valid
m_read  out  1  single-tick read command to master
m_write  out  1  single-tick write command to master
m_addr  out  4  command address (drives the master's read and write address inputs)
m_wdata  out  8  command write data
m_rd_done  in  1  one-cycle pulse: read data captured by master
m_rdata  in  8  read data, valid with m_rd_done
m_wr_done  in  1  one-cycle pulse: write response captured by master
m_bresp  in  4  write response, valid with m_wr_done

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; timeout counter 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid, pick a winner by round-robin, starting the search at the pointer.
  - Latch the winner's index, direction, address and wdata; pulse req_ready[winner].
  - Go to ISSUE. Pointer becomes (winner+1) mod NUM_REQ.
- ISSUE: drive m_read or m_write high for exactly one cycle, with m_addr/m_wdata from the latch; go to WAIT.
- m_addr/m_wdata hold their latched value from ISSUE until leaving WAIT; 0 otherwise.
- WAIT:
  - Only the done pulse matching the latched direction is accepted; the other is ignored.
  - On a matching done: capture m_rdata (read) or m_bresp (write) and go to RESP.
  - On a read completion rsp_code = 0; on a write completion rsp_rdata = 0.
  - Counter increments each WAIT cycle. On reaching TIMEOUT_CYCLES with no done, go to RESP with rsp_code = TIMEOUT_CODE, rsp_rdata = 0.
  - A done pulse arriving in the same cycle the count is reached wins over the timeout.
- RESP: rsp_valid[winner] high for one cycle; rsp_rdata/rsp_code held only that cycle, else 0; return to IDLE.
- Latency: grant to m_read/m_write is 1 cycle. Done pulse to rsp_valid is 1 cycle. Minimum command-to-command spacing is 4 cycles.
- A requester must hold req_valid and its payload until req_ready. Deasserting req_valid before grant withdraws the request, with no side effects.
- Done pulses arriving in IDLE, ISSUE or RESP are dropped.
- Reset mid-transaction returns to IDLE immediately; no response is issued for the aborted transaction.
- req_ready and rsp_valid are never high for two requesters in the same cycle.

Optional Feature:
AXIL_ARB_FIXED_PRIO_EN
- Defined: fixed priority, lowest index wins; the pointer register is removed.
- Undefined (default): round-robin as above.

Decomposition:
- Package axil_arb_pkg holds:
  - the state enum;
  - address width 4, data width 8 and response width 4 constants;
  - the TIMEOUT_CODE default.
- One sub-module, axil_rr_pick: combinational round-robin/fixed-priority picker. Inputs: request vector and pointer. Outputs: one-hot grant and index.

Test Plan:
- Single read: requester 1 reads addr 4'h3; m_rd_done with m_rdata 8'hA5 two cycles after m_read -> rsp_valid = 4'b0010, rsp_rdata = 8'hA5, rsp_code = 0.
- Single write: requester 0 writes 8'h5C to addr 4'h7 -> m_write pulse with m_addr 4'h7 and m_wdata 8'h5C; m_bresp 4'h0 -> rsp_code 0 on requester 0.
- Fairness: all 4 requesters valid continuously -> grant order 0,1,2,3,0 (with the macro: 0,0,0...).
- Timeout: TIMEOUT_CYCLES = 8, no done pulse -> rsp_code 4'hF exactly 8 WAIT cycles after entry; next grant proceeds normally.
- Wrong-direction/stray done: m_wr_done during a read WAIT, and m_rd_done in IDLE -> both ignored; correct read completes later.
- Reset during WAIT -> all outputs 0 next cycle, no rsp_valid; a new request after reset is granted from index 0.
